// File: rtl/frogger_pkg.sv
// Shared constants and types for the Frogger gameplay core: tile widths,
// per-car lane table and the frog state encoding.
package frogger_pkg;

    localparam int NUM_CARS = 8;
    localparam int X_W      = 5;
    localparam int Y_W      = 4;
    localparam int LEVEL_W  = 7;

    // Per-car lane table, index 0..NUM_CARS-1
    localparam int LANE_ROW    [NUM_CARS] = '{12, 11, 10, 9, 8, 5, 4, 3};
    localparam int CAR_INIT_X  [NUM_CARS] = '{0, 19, 3, 4, 10, 4, 5, 6};
    localparam int DIR         [NUM_CARS] = '{1, 0, 1, 0, 1, 0, 1, 0};
    localparam int BASE_PERIOD [NUM_CARS] = '{6, 4, 5, 7, 3, 4, 6, 5};

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_HIT,
        ST_GOAL
    } frog_state_t;

    // Cars speed up with level but never faster than one column per tick.
    function automatic logic [LEVEL_W-1:0] car_period(input int base,
                                                      input logic [LEVEL_W-1:0] level);
        int diff;
        diff = base - int'(level);
        if (diff < 1) begin
            return LEVEL_W'(1);
        end
        return LEVEL_W'(diff);
    endfunction

endpackage

// File: rtl/frogger_car_lane.sv
// One car moving along a fixed lane; steps one column every period ticks,
// where the period shrinks as the level rises.
module car_lane
    import frogger_pkg::*;
#(
    parameter int INIT_X      = 0,
    parameter int DIR         = 1,
    parameter int BASE_PERIOD = 6,
    parameter int GAME_WIDTH  = 20
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               tick,
    input  logic [LEVEL_W-1:0] level,
    output logic [X_W-1:0]     x
);

    localparam logic [X_W-1:0] X_MAX  = X_W'(GAME_WIDTH - 1);
    localparam logic [X_W-1:0] X_INIT = X_W'(INIT_X);

    logic [LEVEL_W-1:0] cnt_reg, cnt_next;
    logic [X_W-1:0]     x_reg, x_next;
    logic [LEVEL_W-1:0] period;

    always_comb begin
        period   = car_period(BASE_PERIOD, level);
        cnt_next = cnt_reg;
        x_next   = x_reg;
        if (tick) begin
            // >= so a counter stranded above a freshly shortened period still fires
            if (cnt_reg >= period - 1'b1) begin
                cnt_next = '0;
                if (DIR != 0) begin
                    x_next = (x_reg == X_MAX) ? '0 : x_reg + 1'b1;
                end else begin
                    x_next = (x_reg == '0) ? X_MAX : x_reg - 1'b1;
                end
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_reg <= '0;
            x_reg   <= X_INIT;
        end else begin
            cnt_reg <= cnt_next;
            x_reg   <= x_next;
        end
    end

    assign x = x_reg;

endmodule

// File: rtl/frogger_play_engine.sv
// Frogger gameplay core: game tick, button-driven frog, car lanes,
// collision detection and level progression.
module frogger_play_engine
    import frogger_pkg::*;
#(
    parameter int GAME_WIDTH  = 20,
    parameter int GAME_HEIGHT = 15,
    parameter int TICK_DIV    = 2500000,
    parameter int MAX_LEVEL   = 99
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Up_Mvt,
    input  logic                    i_Down_Mvt,
    input  logic                    i_Left_Mvt,
    input  logic                    i_Right_Mvt,
    output logic [X_W-1:0]          o_Frogger_X,
    output logic [Y_W-1:0]          o_Frogger_Y,
    output logic [NUM_CARS*X_W-1:0] o_Car_X,
    output logic                    o_Collided,
    output logic [LEVEL_W-1:0]      o_Level
);

    localparam int              TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [X_W-1:0]  START_X = X_W'(GAME_WIDTH / 2);
    localparam logic [Y_W-1:0]  START_Y = Y_W'(GAME_HEIGHT - 1);
    localparam logic [X_W-1:0]  X_MAX   = X_W'(GAME_WIDTH - 1);
    localparam logic [Y_W-1:0]  Y_MAX   = Y_W'(GAME_HEIGHT - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);

    // Game tick: a one-cycle enable, not a clock
    logic [TICK_W-1:0] tick_cnt_reg;
    logic              tick;

    assign tick = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    logic [X_W-1:0]      frog_x_reg, frog_x_next;
    logic [Y_W-1:0]      frog_y_reg, frog_y_next;
    logic [LEVEL_W-1:0]  level_reg, level_next;
    frog_state_t         state_reg, state_next;
    logic [3:0]          btn_now, btn_prev_reg, btn_rise;
    logic [X_W-1:0]      car_x [NUM_CARS];
    logic [NUM_CARS-1:0] hit_vec;
    logic                collide;

    generate
        for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_car
            car_lane #(
                .INIT_X      (CAR_INIT_X[gi]),
                .DIR         (DIR[gi]),
                .BASE_PERIOD (BASE_PERIOD[gi]),
                .GAME_WIDTH  (GAME_WIDTH)
            ) u_car (
                .i_Clk (i_Clk),
                .i_Rst (i_Rst),
                .tick  (tick),
                .level (level_reg),
                .x     (car_x[gi])
            );
            assign o_Car_X[gi*X_W +: X_W] = car_x[gi];
            assign hit_vec[gi] = (frog_x_reg == car_x[gi]) &&
                                 (frog_y_reg == Y_W'(LANE_ROW[gi]));
        end
    endgenerate

    assign collide  = |hit_vec;
    assign btn_now  = {i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt};
    assign btn_rise = btn_now & ~btn_prev_reg;

    // The highest-priority edge claims the cycle even when its move is clamped.
    always_comb begin
        state_next  = ST_PLAY;
        frog_x_next = frog_x_reg;
        frog_y_next = frog_y_reg;
        level_next  = level_reg;
        if (collide) begin
            state_next  = ST_HIT;
            frog_x_next = START_X;
            frog_y_next = START_Y;
        end else if (frog_y_reg == '0) begin
            state_next  = ST_GOAL;
            frog_x_next = START_X;
            frog_y_next = START_Y;
            level_next  = (level_reg >= LEVEL_MAX) ? level_reg : level_reg + 1'b1;
        end else if (btn_rise[3]) begin
            frog_y_next = frog_y_reg - 1'b1;
        end else if (btn_rise[2]) begin
            if (frog_y_reg != Y_MAX) frog_y_next = frog_y_reg + 1'b1;
        end else if (btn_rise[1]) begin
            if (frog_x_reg != '0) frog_x_next = frog_x_reg - 1'b1;
        end else if (btn_rise[0]) begin
            if (frog_x_reg != X_MAX) frog_x_next = frog_x_reg + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_reg    <= ST_PLAY;
            frog_x_reg   <= START_X;
            frog_y_reg   <= START_Y;
            level_reg    <= '0;
            btn_prev_reg <= '0;
        end else begin
            state_reg    <= state_next;
            frog_x_reg   <= frog_x_next;
            frog_y_reg   <= frog_y_next;
            level_reg    <= level_next;
            btn_prev_reg <= btn_now;
        end
    end

    assign o_Frogger_X = frog_x_reg;
    assign o_Frogger_Y = frog_y_reg;
    assign o_Level     = level_reg;
    assign o_Collided  = (state_reg == ST_HIT);

endmodule

// File: tb/tb_frogger_play_engine.sv
// Self-checking bench for frogger_play_engine: directed scenarios plus
// randomized buttons checked against a behavioural game model.
module tb_frogger_play_engine;

    localparam int TD = 4;
    localparam int GW = 20;
    localparam int GH = 15;
    localparam int ML = 5;

    localparam int T_ROW  [8] = '{12, 11, 10, 9, 8, 5, 4, 3};
    localparam int T_INIT [8] = '{0, 19, 3, 4, 10, 4, 5, 6};
    localparam int T_DIR  [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    localparam int T_BASE [8] = '{6, 4, 5, 7, 3, 4, 6, 5};

    logic        clk, rst;
    logic        up, down, left, right;
    logic [4:0]  fx;
    logic [3:0]  fy;
    logic [39:0] car_x;
    logic        collided;
    logic [6:0]  level;

    frogger_play_engine #(
        .GAME_WIDTH  (GW),
        .GAME_HEIGHT (GH),
        .TICK_DIV    (TD),
        .MAX_LEVEL   (ML)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Up_Mvt    (up),
        .i_Down_Mvt  (down),
        .i_Left_Mvt  (left),
        .i_Right_Mvt (right),
        .o_Frogger_X (fx),
        .o_Frogger_Y (fy),
        .o_Car_X     (car_x),
        .o_Collided  (collided),
        .o_Level     (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Game model state
    int m_fx, m_fy, m_lvl, m_col, m_cyc;
    int m_cx  [8];
    int m_cnt [8];
    bit [3:0] m_prev;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fx = GW / 2; m_fy = GH - 1; m_lvl = 0; m_col = 0; m_cyc = 0; m_prev = '0;
        for (int i = 0; i < 8; i++) begin
            m_cx[i]  = T_INIT[i];
            m_cnt[i] = 0;
        end
    endtask

    // Advances the model by one clock edge from the inputs seen at that edge.
    task automatic model_step(input bit [3:0] b);
        bit  tick, hit;
        int  old_lvl, per;
        bit [3:0] rise;
        tick = (m_cyc % TD) == TD - 1;
        hit = 0;
        for (int i = 0; i < 8; i++)
            if (m_fx == m_cx[i] && m_fy == T_ROW[i]) hit = 1;
        old_lvl = m_lvl;
        m_col = 0;
        if (hit) begin
            m_col = 1; m_fx = GW / 2; m_fy = GH - 1;
        end else if (m_fy == 0) begin
            m_lvl = (m_lvl + 1 > ML) ? ML : m_lvl + 1;
            m_fx = GW / 2; m_fy = GH - 1;
        end else begin
            rise = b & ~m_prev;
            if (rise[3])      m_fy = (m_fy > 0) ? m_fy - 1 : 0;
            else if (rise[2]) m_fy = (m_fy < GH - 1) ? m_fy + 1 : GH - 1;
            else if (rise[1]) m_fx = (m_fx > 0) ? m_fx - 1 : 0;
            else if (rise[0]) m_fx = (m_fx < GW - 1) ? m_fx + 1 : GW - 1;
        end
        if (tick) begin
            for (int i = 0; i < 8; i++) begin
                per = (T_BASE[i] - old_lvl < 1) ? 1 : T_BASE[i] - old_lvl;
                if (m_cnt[i] >= per - 1) begin
                    m_cnt[i] = 0;
                    m_cx[i]  = (m_cx[i] + (T_DIR[i] != 0 ? 1 : GW - 1)) % GW;
                end else begin
                    m_cnt[i]++;
                end
            end
        end
        m_prev = b;
        m_cyc++;
    endtask

    task automatic compare_all();
        logic [39:0] e;
        for (int i = 0; i < 8; i++) e[i*5 +: 5] = 5'(m_cx[i]);
        check_eq("frog_x",   64'(fx),       64'(m_fx));
        check_eq("frog_y",   64'(fy),       64'(m_fy));
        check_eq("level",    64'(level),    64'(m_lvl));
        check_eq("collided", 64'(collided), 64'(m_col));
        check_eq("cars",     64'(car_x),    64'(e));
    endtask

    // One transaction: drive buttons, take one edge, check against the model.
    task automatic step(input bit [3:0] b);
        {up, down, left, right} = b;
        @(posedge clk);
        model_step(b);
        #1;
        compare_all();
        $display("cyc %0d btn=%b frog=(%0d,%0d) lvl=%0d col=%0d car0=%0d car1=%0d",
                 m_cyc, b, fx, fy, level, collided, car_x[4:0], car_x[9:5]);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_x"},    64'(fx),          64'(10));
        check_eq({tag, "_y"},    64'(fy),          64'(14));
        check_eq({tag, "_car0"}, 64'(car_x[4:0]),  64'(0));
        check_eq({tag, "_car1"}, 64'(car_x[9:5]),  64'(19));
        check_eq({tag, "_lvl"},  64'(level),       64'(0));
        check_eq({tag, "_col"},  64'(collided),    64'(0));
    endtask

    task automatic do_reset();
        {up, down, left, right} = 4'b0000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        compare_all();
    endtask

    initial begin
        bit [3:0] b;
        rst = 1'b1;
        {up, down, left, right} = 4'b0000;

        // Reset values and car timing at level 0
        do_reset();
        check_reset_values("reset");
        for (int n = 1; n <= 330; n++) begin
            step(4'b0000);
            if (n == 16)  check_eq("car1_first_move", 64'(car_x[9:5]), 64'(18));
            if (n == 23)  check_eq("car0_before_move", 64'(car_x[4:0]), 64'(0));
            if (n == 24)  check_eq("car0_first_move", 64'(car_x[4:0]), 64'(1));
            if (n == 48)  check_eq("car0_second_move", 64'(car_x[4:0]), 64'(2));
            if (n == 304) check_eq("car1_at_zero", 64'(car_x[9:5]), 64'(0));
            if (n == 320) check_eq("car1_wrap", 64'(car_x[9:5]), 64'(19));
        end

        // Held button moves once; coincident edges follow priority
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            step(4'b1000);
            check_eq("up_held_y", 64'(fy), 64'(13));
        end
        step(4'b0000);
        step(4'b1010);
        check_eq("up_left_y", 64'(fy), 64'(12));
        check_eq("up_left_x", 64'(fx), 64'(10));

        // Clamping at the edges of the playfield
        do_reset();
        step(4'b0100);
        check_eq("clamp_down_y", 64'(fy), 64'(14));
        step(4'b0000);
        for (int k = 0; k < 10; k++) begin
            step(4'b0010);
            step(4'b0000);
        end
        check_eq("left_to_0", 64'(fx), 64'(0));
        step(4'b0010);
        check_eq("clamp_left_x", 64'(fx), 64'(0));
        step(4'b0000);
        for (int k = 0; k < 19; k++) begin
            step(4'b0001);
            step(4'b0000);
        end
        check_eq("right_to_19", 64'(fx), 64'(19));
        step(4'b0001);
        check_eq("clamp_right_x", 64'(fx), 64'(19));

        // Collision with car0 on row 12, column 0
        do_reset();
        for (int n = 1; n <= 24; n++) begin
            if (n <= 19 && (n % 2) == 1) b = 4'b0010;
            else if (n == 20 || n == 22) b = 4'b1000;
            else b = 4'b0000;
            step(b);
            if (n == 22) begin
                check_eq("pre_hit_x", 64'(fx), 64'(0));
                check_eq("pre_hit_y", 64'(fy), 64'(12));
                check_eq("pre_hit_col", 64'(collided), 64'(0));
            end
            if (n == 23) begin
                check_eq("hit_col", 64'(collided), 64'(1));
                check_eq("hit_x", 64'(fx), 64'(10));
                check_eq("hit_y", 64'(fy), 64'(14));
                check_eq("hit_lvl", 64'(level), 64'(0));
            end
            if (n == 24) check_eq("hit_pulse_end", 64'(collided), 64'(0));
        end

        // Goal via column 9, then car0 at the level-1 period
        do_reset();
        for (int n = 1; n <= 84; n++) begin
            if (n == 1) b = 4'b0010;
            else if (n >= 3 && n <= 29 && (n % 2) == 1) b = 4'b1000;
            else b = 4'b0000;
            step(b);
            if (n == 29) begin
                check_eq("goal_y", 64'(fy), 64'(0));
                check_eq("goal_x", 64'(fx), 64'(9));
                check_eq("goal_lvl_before", 64'(level), 64'(0));
            end
            if (n == 30) begin
                check_eq("goal_lvl", 64'(level), 64'(1));
                check_eq("goal_ret_x", 64'(fx), 64'(10));
                check_eq("goal_ret_y", 64'(fy), 64'(14));
            end
            if (n == 43) check_eq("lvl1_car0_hold", 64'(car_x[4:0]), 64'(1));
            if (n == 44) check_eq("lvl1_car0_move", 64'(car_x[4:0]), 64'(2));
            if (n == 63) check_eq("lvl1_car0_p5a", 64'(car_x[4:0]), 64'(2));
            if (n == 64) check_eq("lvl1_car0_p5b", 64'(car_x[4:0]), 64'(3));
            if (n == 84) check_eq("lvl1_car0_p5c", 64'(car_x[4:0]), 64'(4));
        end

        // Randomized play against the model, with one asynchronous reset
        do_reset();
        for (int n = 1; n <= 4000; n++) begin
            b[3] = ($urandom_range(0, 2) == 0);
            b[2] = ($urandom_range(0, 7) == 0);
            b[1] = ($urandom_range(0, 4) == 0);
            b[0] = ($urandom_range(0, 4) == 0);
            step(b);
            if (n == 2000) begin
                #3;
                rst = 1'b1;
                #1;
                check_reset_values("async_rst");
                @(posedge clk);
                #1;
                rst = 1'b0;
                {up, down, left, right} = 4'b0000;
                model_reset();
                compare_all();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
